// File: rtl/fetch_unit_if.sv
// Opcode/instruction-memory interface between the fetch stage, the instruction
// memory and the decode stage. The fetch side drives the memory address and the
// IF/ID register outputs; the environment side supplies memory data, stall and flush.
interface fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               flush;
  logic [ADDR_W-1:0]  flush_pc;
  logic [INSTR_W-1:0] if_instr;
  logic [INSTR_W-1:0] if_imm;
  logic [ADDR_W-1:0]  if_pc;
  logic               if_valid;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  stall,
    input  flush,
    input  flush_pc,
    output if_instr,
    output if_imm,
    output if_pc,
    output if_valid
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output stall,
    output flush,
    output flush_pc,
    input  if_instr,
    input  if_imm,
    input  if_pc,
    input  if_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Presents PC to instruction memory, registers each
// fetched word into the IF/ID register and assembles two-word LDM (opcode 00001)
// so that decode sees the opcode word and its immediate in a single valid cycle.
// Priority at every edge: flush, then stall, then normal fetch.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst_n,
  fetch_unit_if.master bus
);

  localparam logic [4:0] OP_LDM = 5'b00001;

  typedef enum logic {
    S_FETCH     = 1'b0,
    S_FETCH_IMM = 1'b1
  } state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] hold_q;
  logic [ADDR_W-1:0]  hold_pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] imm_q;
  logic [ADDR_W-1:0]  ipc_q;
  logic               valid_q;

  logic [ADDR_W-1:0]  pc_d;
  logic               is_ldm;

  // Sequential PC increment wraps naturally at the address width.
  assign pc_d   = pc_q + 1'b1;
  assign is_ldm = (bus.imem_rdata[INSTR_W-1 -: 5] == OP_LDM);

  assign bus.imem_addr = pc_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_imm    = imm_q;
  assign bus.if_pc     = ipc_q;
  assign bus.if_valid  = valid_q;

  // Fetch FSM and IF/ID register: flush redirects, stall freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      hold_q    <= '0;
      hold_pc_q <= '0;
      instr_q   <= '0;
      imm_q     <= '0;
      ipc_q     <= '0;
      valid_q   <= 1'b0;
    end else if (bus.flush) begin
      // Any half-assembled LDM is dropped; the IF/ID payload is left as is.
      state_q <= S_FETCH;
      pc_q    <= bus.flush_pc;
      valid_q <= 1'b0;
    end else if (!bus.stall) begin
      case (state_q)
        S_FETCH: begin
          pc_q <= pc_d;
          if (is_ldm) begin
            // Park the LDM word and emit a bubble while the immediate is read.
            hold_q    <= bus.imem_rdata;
            hold_pc_q <= pc_q;
            valid_q   <= 1'b0;
            state_q   <= S_FETCH_IMM;
          end else begin
            instr_q <= bus.imem_rdata;
            imm_q   <= '0;
            ipc_q   <= pc_q;
            valid_q <= 1'b1;
          end
        end
        S_FETCH_IMM: begin
          // The current word is the immediate; it is never treated as an opcode.
          instr_q <= hold_q;
          imm_q   <= bus.imem_rdata;
          ipc_q   <= hold_pc_q;
          valid_q <= 1'b1;
          pc_q    <= pc_d;
          state_q <= S_FETCH;
        end
        default: begin
          state_q <= S_FETCH;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed table of per-cycle vectors, hand-written
// sequences for reset, wrap-around and reset during LDM assembly, then random
// memory contents and random stall/flush checked against an instruction-stream model.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  logic [15:0] imem [0:65535];

  int checks;
  int errors;

  fetch_unit_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

  fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.imem_rdata = imem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [15:0] fpc;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [15:0] e_imm;
    logic [15:0] e_pc;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] addr, input logic valid,
                         input logic [15:0] instr, input logic [15:0] imm, input logic [15:0] pc);
    chk({tag, ".imem_addr"}, bus.imem_addr, addr);
    chk({tag, ".if_valid"}, {15'd0, bus.if_valid}, {15'd0, valid});
    chk({tag, ".if_instr"}, bus.if_instr, instr);
    chk({tag, ".if_imm"}, bus.if_imm, imm);
    chk({tag, ".if_pc"}, bus.if_pc, pc);
  endtask

  // Drive inputs between edges, then sample just after the next rising edge.
  task automatic step(input logic s, input logic f, input logic [15:0] fpc);
    bus.stall    = s;
    bus.flush    = f;
    bus.flush_pc = fpc;
    @(posedge clk);
    #1;
  endtask

  // Reference model state: an instruction stream with at most one LDM pending.
  logic [15:0] m_pc, m_hold, m_hold_pc, m_instr, m_imm, m_ipc;
  logic        m_pend, m_valid;

  initial begin
    checks = 0;
    errors = 0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    bus.flush_pc = 16'h0000;
    for (int i = 0; i < 65536; i++) imem[i] = 16'h0000;
    imem[0] = 16'h1800; imem[1] = 16'h2000; imem[2] = 16'h3000; imem[3] = 16'h2800;
    imem[4] = 16'h0800; imem[5] = 16'hBEEF; imem[6] = 16'h2A00; imem[7] = 16'h0800;
    imem[8] = 16'h1111; imem[16'h0040] = 16'h3800;

    // Asynchronous reset applied mid-cycle must take effect before any edge.
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_all("reset_async", 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    $display("reset asserted mid-cycle: addr=%h valid=%b", bus.imem_addr, bus.if_valid);
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    //        stall flush fpc      addr      v     instr     imm       pc
    vt[0]  = '{1'b0, 1'b0, 16'h0000, 16'h0001, 1'b1, 16'h1800, 16'h0000, 16'h0000};
    vt[1]  = '{1'b0, 1'b0, 16'h0000, 16'h0002, 1'b1, 16'h2000, 16'h0000, 16'h0001};
    vt[2]  = '{1'b1, 1'b0, 16'h0000, 16'h0002, 1'b1, 16'h2000, 16'h0000, 16'h0001};
    vt[3]  = '{1'b1, 1'b0, 16'h0000, 16'h0002, 1'b1, 16'h2000, 16'h0000, 16'h0001};
    vt[4]  = '{1'b1, 1'b0, 16'h0000, 16'h0002, 1'b1, 16'h2000, 16'h0000, 16'h0001};
    vt[5]  = '{1'b0, 1'b0, 16'h0000, 16'h0003, 1'b1, 16'h3000, 16'h0000, 16'h0002};
    vt[6]  = '{1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 16'h2800, 16'h0000, 16'h0003};
    vt[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0005, 1'b0, 16'h2800, 16'h0000, 16'h0003};
    vt[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0006, 1'b1, 16'h0800, 16'hBEEF, 16'h0004};
    vt[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0007, 1'b1, 16'h2A00, 16'h0000, 16'h0006};
    vt[10] = '{1'b0, 1'b0, 16'h0000, 16'h0008, 1'b0, 16'h2A00, 16'h0000, 16'h0006};
    vt[11] = '{1'b1, 1'b1, 16'h0040, 16'h0040, 1'b0, 16'h2A00, 16'h0000, 16'h0006};
    vt[12] = '{1'b0, 1'b0, 16'h0000, 16'h0041, 1'b1, 16'h3800, 16'h0000, 16'h0040};

    for (int i = 0; i < 13; i++) begin
      step(vt[i].stall, vt[i].flush, vt[i].fpc);
      chk_all($sformatf("vec%0d", i), vt[i].e_addr, vt[i].e_valid,
              vt[i].e_instr, vt[i].e_imm, vt[i].e_pc);
      $display("vec%0d stall=%b flush=%b addr=%h valid=%b instr=%h imm=%h pc=%h",
               i, vt[i].stall, vt[i].flush, bus.imem_addr, bus.if_valid,
               bus.if_instr, bus.if_imm, bus.if_pc);
    end

    // LDM at the top of the address space takes its immediate from address 0.
    imem[16'hFFFF] = 16'h0800;
    imem[16'h0000] = 16'h1234;
    step(1'b0, 1'b1, 16'hFFFF);
    chk("wrap.redirect_addr", bus.imem_addr, 16'hFFFF);
    step(1'b0, 1'b0, 16'h0000);
    chk("wrap.bubble_valid", {15'd0, bus.if_valid}, 16'h0000);
    chk("wrap.pc_wrapped", bus.imem_addr, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    chk_all("wrap.emit", 16'h0001, 1'b1, 16'h0800, 16'h1234, 16'hFFFF);
    $display("wrap: instr=%h imm=%h pc=%h next_addr=%h",
             bus.if_instr, bus.if_imm, bus.if_pc, bus.imem_addr);

    // Reset while an LDM is half-assembled must abandon it.
    imem[16'h0000] = 16'h1800;
    step(1'b0, 1'b1, 16'h0004);
    step(1'b0, 1'b0, 16'h0000);
    chk("rstimm.bubble_valid", {15'd0, bus.if_valid}, 16'h0000);
    chk("rstimm.imm_addr", bus.imem_addr, 16'h0005);
    #2 rst_n = 1'b0;
    #1;
    chk_all("rstimm.async", 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    @(posedge clk); #1;
    chk_all("rstimm.held", 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    #2 rst_n = 1'b1;
    step(1'b0, 1'b0, 16'h0000);
    chk_all("rstimm.resume", 16'h0001, 1'b1, 16'h1800, 16'h0000, 16'h0000);
    $display("reset in LDM: resumed instr=%h pc=%h valid=%b",
             bus.if_instr, bus.if_pc, bus.if_valid);

    // Random program, random stall/flush, compared each cycle with the model.
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 3) == 0) w[15:11] = 5'b00001;
      imem[i] = w;
    end
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    m_pc = 16'h0000; m_pend = 1'b0; m_hold = '0; m_hold_pc = '0;
    m_instr = '0; m_imm = '0; m_ipc = '0; m_valid = 1'b0;
    begin
      int rerr;
      rerr = errors;
      for (int c = 0; c < 600; c++) begin
        logic s, f;
        logic [15:0] fpc, w;
        s   = ($urandom_range(0, 4) == 0);
        f   = ($urandom_range(0, 19) == 0);
        fpc = 16'($urandom);
        if (f) begin
          m_pc = fpc; m_pend = 1'b0; m_valid = 1'b0;
        end else if (!s) begin
          w = imem[m_pc];
          if (m_pend) begin
            m_instr = m_hold; m_imm = w; m_ipc = m_hold_pc;
            m_valid = 1'b1; m_pend = 1'b0;
          end else if (w[15:11] == 5'b00001) begin
            m_hold = w; m_hold_pc = m_pc; m_valid = 1'b0; m_pend = 1'b1;
          end else begin
            m_instr = w; m_imm = 16'h0000; m_ipc = m_pc; m_valid = 1'b1;
          end
          m_pc = m_pc + 16'h0001;
        end
        step(s, f, fpc);
        chk_all($sformatf("rand%0d", c), m_pc, m_valid, m_instr, m_imm, m_ipc);
      end
      $display("random phase: 600 cycles, %0d new errors", errors - rerr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
